// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the MS108 CPU.
// Latches the instruction and operands, decodes the opcode into an ALU op
// and immediate-select bit, applies prioritised forwarding, and supports
// stall, flush, illegal-opcode detection and a saturating stall counter.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int IR_W    = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic [IR_W-1:0]           IR_i,
    input  logic [DATA_W-1:0]         data1_i,
    input  logic [DATA_W-1:0]         data2_i,
    input  logic [DATA_W-1:0]         data3_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_hit1_i,
    input  logic [NUM_FWD-1:0]        fwd_hit2_i,
    output logic [IR_W-1:0]           IR_o,
    output logic [DATA_W-1:0]         data1_o,
    output logic [DATA_W-1:0]         data2_o,
    output logic [DATA_W-1:0]         data3_o,
    output logic [2:0]                op_o,
    output logic                      control_o,
    output logic                      valid_o,
    output logic                      illegal_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_MUL = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_BGE = 3'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]        opcode;
    logic              dec_legal;
    logic [2:0]        dec_op;
    logic              dec_ctrl;
    logic              dec_zero_d1;
    logic [DATA_W-1:0] map_d1;
    logic [DATA_W-1:0] map_d2;
    logic [DATA_W-1:0] map_d3;
    logic [DATA_W-1:0] fwd_d1;
    logic [DATA_W-1:0] fwd_d2;

    assign opcode = IR_i[IR_W-1 -: 4];

    // Decode opcode into ALU op, immediate select and operand mapping
    always_comb begin
        dec_legal   = 1'b1;
        dec_op      = OP_ADD;
        dec_ctrl    = 1'b0;
        dec_zero_d1 = 1'b0;
        map_d1      = data1_i;
        map_d2      = data2_i;
        map_d3      = data3_i;
        case (opcode)
            4'h0, 4'h1, 4'h4: begin
                dec_ctrl = 1'b1;
            end
            4'h3: begin
                dec_ctrl = 1'b0;
            end
            4'h5: begin
                dec_op   = OP_SLL;
                dec_ctrl = 1'b1;
            end
            4'h6: begin
                dec_op = OP_MUL;
            end
            4'h9: begin
                dec_op   = OP_MUL;
                dec_ctrl = 1'b1;
            end
            4'h2, 4'h8: begin
                dec_ctrl    = 1'b1;
                dec_zero_d1 = 1'b1;
                map_d1      = '0;
                map_d3      = '0;
            end
            4'h7: begin
                dec_op   = OP_BGE;
                dec_ctrl = 1'b1;
                map_d2   = data3_i;
                map_d3   = data2_i;
            end
            default: begin
                dec_legal = 1'b0;
                map_d1    = '0;
                map_d2    = '0;
                map_d3    = '0;
            end
        endcase
    end

    // Forwarding: lowest-index hit wins, so scan from the highest index down
    always_comb begin
        fwd_d1 = map_d1;
        fwd_d2 = map_d2;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_hit1_i[k] && !dec_zero_d1) begin
                fwd_d1 = fwd_data_i[k*DATA_W +: DATA_W];
            end
            if (fwd_hit2_i[k]) begin
                fwd_d2 = fwd_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Pipeline register: reset > flush > stall > capture (or bubble)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            IR_o        <= '0;
            data1_o     <= '0;
            data2_o     <= '0;
            data3_o     <= '0;
            op_o        <= OP_ADD;
            control_o   <= 1'b0;
            valid_o     <= 1'b0;
            illegal_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else if (flush_i) begin
            IR_o      <= '0;
            data1_o   <= '0;
            data2_o   <= '0;
            data3_o   <= '0;
            op_o      <= OP_ADD;
            control_o <= 1'b0;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end else if (stall_i) begin
            illegal_o <= 1'b0;
            if (stall_cnt_o != CNT_MAX) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
        end else if (valid_i) begin
            IR_o      <= IR_i;
            valid_o   <= dec_legal;
            illegal_o <= !dec_legal;
            if (dec_legal) begin
                data1_o   <= fwd_d1;
                data2_o   <= fwd_d2;
                data3_o   <= map_d3;
                op_o      <= dec_op;
                control_o <= dec_ctrl;
            end else begin
                data1_o   <= '0;
                data2_o   <= '0;
                data3_o   <= '0;
                op_o      <= OP_ADD;
                control_o <= 1'b0;
            end
        end else begin
            IR_o      <= '0;
            data1_o   <= '0;
            data2_o   <= '0;
            data3_o   <= '0;
            op_o      <= OP_ADD;
            control_o <= 1'b0;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
// A second instance with a 4-bit stall counter shares the inputs so that
// saturation can be reached in a few cycles.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] IR_i;
    logic [31:0] data1_i, data2_i, data3_i;
    logic [63:0] fwd_data_i;
    logic [1:0]  fwd_hit1_i, fwd_hit2_i;

    logic [31:0] IR_o, data1_o, data2_o, data3_o;
    logic [2:0]  op_o;
    logic        control_o, valid_o, illegal_o;
    logic [15:0] stall_cnt_o;

    logic [31:0] s_IR_o, s_data1_o, s_data2_o, s_data3_o;
    logic [2:0]  s_op_o;
    logic        s_control_o, s_valid_o, s_illegal_o;
    logic [3:0]  s_stall_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage #(.DATA_W(32), .IR_W(32), .NUM_FWD(2), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .flush_i(flush_i), .IR_i(IR_i), .data1_i(data1_i), .data2_i(data2_i),
        .data3_i(data3_i), .fwd_data_i(fwd_data_i), .fwd_hit1_i(fwd_hit1_i),
        .fwd_hit2_i(fwd_hit2_i), .IR_o(IR_o), .data1_o(data1_o),
        .data2_o(data2_o), .data3_o(data3_o), .op_o(op_o),
        .control_o(control_o), .valid_o(valid_o), .illegal_o(illegal_o),
        .stall_cnt_o(stall_cnt_o)
    );

    id_ex_stage #(.DATA_W(32), .IR_W(32), .NUM_FWD(2), .CNT_W(4)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .flush_i(flush_i), .IR_i(IR_i), .data1_i(data1_i), .data2_i(data2_i),
        .data3_i(data3_i), .fwd_data_i(fwd_data_i), .fwd_hit1_i(fwd_hit1_i),
        .fwd_hit2_i(fwd_hit2_i), .IR_o(s_IR_o), .data1_o(s_data1_o),
        .data2_o(s_data2_o), .data3_o(s_data3_o), .op_o(s_op_o),
        .control_o(s_control_o), .valid_o(s_valid_o), .illegal_o(s_illegal_o),
        .stall_cnt_o(s_stall_cnt_o)
    );

    // Drive one cycle of stimulus, clock it in, and settle 1 ns past the edge
    task automatic drive(input logic v, input logic st, input logic fl,
                         input logic [31:0] ir, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3,
                         input logic [63:0] fd, input logic [1:0] h1,
                         input logic [1:0] h2);
        valid_i    = v;
        stall_i    = st;
        flush_i    = fl;
        IR_i       = ir;
        data1_i    = d1;
        data2_i    = d2;
        data3_i    = d3;
        fwd_data_i = fd;
        fwd_hit1_i = h1;
        fwd_hit2_i = h2;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom, $urandom, $urandom, $urandom,
                  {$urandom, $urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end
        rst_i = 1'b0;
        n_checks++; if (IR_o !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_IR got %h exp 0", IR_o); end
        n_checks++; if ({data1_o, data2_o, data3_o} !== 96'h0) begin n_fail++; $display("[TB] FAIL reset_data got %h %h %h exp 0", data1_o, data2_o, data3_o); end
        n_checks++; if ({op_o, control_o, valid_o, illegal_o} !== 6'h0) begin n_fail++; $display("[TB] FAIL reset_ctrl got op=%0d c=%b v=%b i=%b exp 0", op_o, control_o, valid_o, illegal_o); end
        n_checks++; if (stall_cnt_o !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_cnt got %0d exp 0", stall_cnt_o); end
    endtask

    task automatic test_bge_forward();
        drive(1, 0, 0, 32'h7000_0000, 32'h11, 32'h22, 32'h33, {32'hAA, 32'h99}, 2'b00, 2'b10);
        n_checks++; if (data1_o !== 32'h11) begin n_fail++; $display("[TB] FAIL bge_data1 got %h exp 11", data1_o); end
        n_checks++; if (data2_o !== 32'hAA) begin n_fail++; $display("[TB] FAIL bge_data2 got %h exp aa", data2_o); end
        n_checks++; if (data3_o !== 32'h22) begin n_fail++; $display("[TB] FAIL bge_data3 got %h exp 22", data3_o); end
        n_checks++; if ({op_o, control_o, valid_o, illegal_o} !== {3'd3, 1'b1, 1'b1, 1'b0}) begin n_fail++; $display("[TB] FAIL bge_ctrl got op=%0d c=%b v=%b i=%b exp op=3 c=1 v=1 i=0", op_o, control_o, valid_o, illegal_o); end
        n_checks++; if (IR_o !== 32'h7000_0000) begin n_fail++; $display("[TB] FAIL bge_IR got %h exp 70000000", IR_o); end
    endtask

    task automatic test_fwd_priority();
        // ADDU with both sources hitting data1; only source 1 hitting data2
        drive(1, 0, 0, 32'h3000_0001, 32'h1, 32'h2, 32'h3, {32'h6, 32'h5}, 2'b11, 2'b10);
        n_checks++; if (data1_o !== 32'h5) begin n_fail++; $display("[TB] FAIL prio_data1 got %h exp 5", data1_o); end
        n_checks++; if (data2_o !== 32'h6) begin n_fail++; $display("[TB] FAIL prio_data2 got %h exp 6", data2_o); end
        n_checks++; if ({op_o, control_o} !== {3'd0, 1'b0}) begin n_fail++; $display("[TB] FAIL prio_ctrl got op=%0d c=%b exp op=0 c=0", op_o, control_o); end
        // No hits: mapped values kept
        drive(1, 0, 0, 32'h3000_0002, 32'h41, 32'h42, 32'h43, {32'h6, 32'h5}, 2'b00, 2'b00);
        n_checks++; if ({data1_o, data2_o, data3_o} !== {32'h41, 32'h42, 32'h43}) begin n_fail++; $display("[TB] FAIL nohit_data got %h %h %h exp 41 42 43", data1_o, data2_o, data3_o); end
    endtask

    task automatic test_decode();
        // LI: data1 forced to 0 even with a hit, data2 forwarded, data3 zero
        drive(1, 0, 0, 32'h2000_1234, 32'h51, 32'h52, 32'h53, {32'h77, 32'h66}, 2'b01, 2'b01);
        n_checks++; if ({data1_o, data2_o, data3_o} !== {32'h0, 32'h66, 32'h0}) begin n_fail++; $display("[TB] FAIL li_data got %h %h %h exp 0 66 0", data1_o, data2_o, data3_o); end
        n_checks++; if ({op_o, control_o, valid_o} !== {3'd0, 1'b1, 1'b1}) begin n_fail++; $display("[TB] FAIL li_ctrl got op=%0d c=%b v=%b exp op=0 c=1 v=1", op_o, control_o, valid_o); end
        drive(1, 0, 0, 32'h9000_0000, 32'h1, 32'h2, 32'h3, 64'h0, 2'b00, 2'b00);
        n_checks++; if ({op_o, control_o} !== {3'd1, 1'b1}) begin n_fail++; $display("[TB] FAIL muli_ctrl got op=%0d c=%b exp op=1 c=1", op_o, control_o); end
        drive(1, 0, 0, 32'h5000_0000, 32'h1, 32'h2, 32'h3, 64'h0, 2'b00, 2'b00);
        n_checks++; if ({op_o, control_o} !== {3'd2, 1'b1}) begin n_fail++; $display("[TB] FAIL sll_ctrl got op=%0d c=%b exp op=2 c=1", op_o, control_o); end
        drive(1, 0, 0, 32'h6000_0000, 32'h1, 32'h2, 32'h3, 64'h0, 2'b00, 2'b00);
        n_checks++; if ({op_o, control_o} !== {3'd1, 1'b0}) begin n_fail++; $display("[TB] FAIL mul_ctrl got op=%0d c=%b exp op=1 c=0", op_o, control_o); end
        // valid_i low captures a full bubble
        drive(0, 0, 0, 32'h3000_0000, 32'h1, 32'h2, 32'h3, 64'h0, 2'b00, 2'b00);
        n_checks++; if ({IR_o, data1_o, valid_o, illegal_o} !== 66'h0) begin n_fail++; $display("[TB] FAIL bubble got IR=%h d1=%h v=%b i=%b exp 0", IR_o, data1_o, valid_o, illegal_o); end
    endtask

    task automatic test_stall_flush();
        drive(1, 0, 0, 32'h3000_00AB, 32'h1, 32'h2, 32'h3, 64'h0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h6000_0000, 32'hF1, 32'hF2, 32'hF3, {32'h88, 32'h99}, 2'b11, 2'b11);
        end
        n_checks++; if (IR_o !== 32'h3000_00AB) begin n_fail++; $display("[TB] FAIL stall_IR got %h exp 300000ab", IR_o); end
        n_checks++; if ({data1_o, data2_o, data3_o} !== {32'h1, 32'h2, 32'h3}) begin n_fail++; $display("[TB] FAIL stall_data got %h %h %h exp 1 2 3", data1_o, data2_o, data3_o); end
        n_checks++; if ({op_o, control_o, valid_o} !== {3'd0, 1'b0, 1'b1}) begin n_fail++; $display("[TB] FAIL stall_ctrl got op=%0d c=%b v=%b exp op=0 c=0 v=1", op_o, control_o, valid_o); end
        n_checks++; if (stall_cnt_o !== 16'd3) begin n_fail++; $display("[TB] FAIL stall_cnt got %0d exp 3", stall_cnt_o); end
        drive(1, 1, 1, 32'h6000_0000, 32'hF1, 32'hF2, 32'hF3, 64'h0, 2'b00, 2'b00);
        n_checks++; if ({valid_o, IR_o, data1_o} !== 65'h0) begin n_fail++; $display("[TB] FAIL flush_out got v=%b IR=%h d1=%h exp 0", valid_o, IR_o, data1_o); end
        n_checks++; if (stall_cnt_o !== 16'd3) begin n_fail++; $display("[TB] FAIL flush_cnt got %0d exp 3", stall_cnt_o); end
    endtask

    task automatic test_illegal();
        drive(1, 0, 0, 32'hC000_0000, 32'h1, 32'h2, 32'h3, {32'h5, 32'h5}, 2'b11, 2'b11);
        n_checks++; if ({valid_o, illegal_o} !== 2'b01) begin n_fail++; $display("[TB] FAIL illegal_flags got v=%b i=%b exp v=0 i=1", valid_o, illegal_o); end
        n_checks++; if (IR_o !== 32'hC000_0000) begin n_fail++; $display("[TB] FAIL illegal_IR got %h exp c0000000", IR_o); end
        n_checks++; if ({data1_o, data2_o, data3_o, op_o, control_o} !== 100'h0) begin n_fail++; $display("[TB] FAIL illegal_clear got %h %h %h op=%0d c=%b exp 0", data1_o, data2_o, data3_o, op_o, control_o); end
        drive(1, 1, 0, 32'h3000_0000, 32'h1, 32'h2, 32'h3, 64'h0, 2'b00, 2'b00);
        n_checks++; if (illegal_o !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_pulse got %b exp 0", illegal_o); end
        n_checks++; if (IR_o !== 32'hC000_0000) begin n_fail++; $display("[TB] FAIL illegal_hold got %h exp c0000000", IR_o); end
    endtask

    task automatic test_saturation();
        rst_i = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 64'h0, 2'b00, 2'b00);
        rst_i = 1'b0;
        n_checks++; if (s_stall_cnt_o !== 4'd0) begin n_fail++; $display("[TB] FAIL sat_reset got %0d exp 0", s_stall_cnt_o); end
        for (int i = 0; i < 14; i++) drive(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 64'h0, 2'b00, 2'b00);
        n_checks++; if (s_stall_cnt_o !== 4'd14) begin n_fail++; $display("[TB] FAIL sat_14 got %0d exp 14", s_stall_cnt_o); end
        drive(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 64'h0, 2'b00, 2'b00);
        n_checks++; if (s_stall_cnt_o !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_15 got %0d exp 15", s_stall_cnt_o); end
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 64'h0, 2'b00, 2'b00);
        n_checks++; if (s_stall_cnt_o !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_hold got %0d exp 15", s_stall_cnt_o); end
        n_checks++; if (stall_cnt_o !== 16'd20) begin n_fail++; $display("[TB] FAIL wide_cnt got %0d exp 20", stall_cnt_o); end
    endtask

    // Run each scenario in order and report the totals
    initial begin
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        IR_i       = '0;
        data1_i    = '0;
        data2_i    = '0;
        data3_i    = '0;
        fwd_data_i = '0;
        fwd_hit1_i = '0;
        fwd_hit2_i = '0;
        #2;
        test_reset();
        test_bge_forward();
        test_fwd_priority();
        test_decode();
        test_stall_flush();
        test_illegal();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
